// File: rtl/pause_frame_tx.sv
// IEEE 802.3x PAUSE frame generator: turns a one-cycle pause request into a byte stream.
// Define PAUSE_FCS_EN to append a CRC-32 FCS; otherwise the MAC appends it.
module pause_frame_tx #(
    parameter logic [47:0] SRC_MAC = 48'h020000000001
) (
    input  logic        tx_clk,
    input  logic        rstn,
    input  logic        tx_pause_req,
    input  logic [15:0] tx_pause_val,
    input  logic [47:0] tx_pause_dest_addr,
    output logic [7:0]  pf_tdata,
    output logic        pf_tvalid,
    input  logic        pf_tready,
    output logic        pf_tlast,
    output logic        tx_pause_busy,
    output logic        tx_pause_done
);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAD, S_FCS} state_t;

`ifdef PAUSE_FCS_EN
    localparam logic [5:0] LAST_IDX = 6'd63;
`else
    localparam logic [5:0] LAST_IDX = 6'd59;
`endif

    state_t      state, state_n;
    logic [5:0]  cnt, cnt_n, nidx;
    logic [47:0] dest_q, dest_n, pend_dest, pdest_n;
    logic [15:0] val_q, val_n, pend_val, pval_n;
    logic        pend_flag, pend_n, restart, restart_n;
    logic [7:0]  tdata_n;
    logic        tvalid_n, tlast_n, busy_n, done_n;
    logic        hs, start;
`ifdef PAUSE_FCS_EN
    logic [31:0] crc_q, crc_n, crc_upd;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h000000, b};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction
`endif

    // Header bytes 0..17 from the latched fields; everything beyond is zero padding.
    function automatic logic [7:0] hdr_byte(input logic [5:0] idx, input logic [47:0] da,
                                            input logic [15:0] v);
        logic [47:0] sh;
        logic [5:0]  k;
        hdr_byte = 8'h00;
        sh = '0;
        k = idx - 6'd6;
        if (idx < 6'd6) begin
            sh = da << {idx[2:0], 3'b000};
            hdr_byte = sh[47:40];
        end else if (idx < 6'd12) begin
            sh = SRC_MAC << {k[2:0], 3'b000};
            hdr_byte = sh[47:40];
        end else begin
            case (idx)
                6'd12:   hdr_byte = 8'h88;
                6'd13:   hdr_byte = 8'h08;
                6'd15:   hdr_byte = 8'h01;
                6'd16:   hdr_byte = v[15:8];
                6'd17:   hdr_byte = v[7:0];
                default: hdr_byte = 8'h00;
            endcase
        end
    endfunction

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        dest_n    = dest_q;
        val_n     = val_q;
        pdest_n   = pend_dest;
        pval_n    = pend_val;
        pend_n    = pend_flag;
        restart_n = restart;
        tdata_n   = pf_tdata;
        tvalid_n  = pf_tvalid;
        tlast_n   = pf_tlast;
        busy_n    = tx_pause_busy;
        done_n    = 1'b0;
        start     = 1'b0;
        nidx      = cnt + 6'd1;
        hs        = pf_tvalid & pf_tready;
`ifdef PAUSE_FCS_EN
        crc_n     = crc_q;
        crc_upd   = crc_byte(crc_q, pf_tdata);
`endif
        case (state)
            S_IDLE: begin
                // A restart carries fields already copied from the pending slot at completion.
                if (restart) begin
                    start     = 1'b1;
                    restart_n = 1'b0;
                    if (tx_pause_req) begin
                        pdest_n = tx_pause_dest_addr;
                        pval_n  = tx_pause_val;
                        pend_n  = 1'b1;
                    end
                end else if (tx_pause_req) begin
                    start  = 1'b1;
                    dest_n = tx_pause_dest_addr;
                    val_n  = tx_pause_val;
                end
            end
            default: begin
                if (tx_pause_req) begin
                    pdest_n = tx_pause_dest_addr;
                    pval_n  = tx_pause_val;
                    pend_n  = 1'b1;
                end
                if (hs) begin
                    if (cnt == LAST_IDX) begin
                        state_n  = S_IDLE;
                        cnt_n    = 6'd0;
                        tdata_n  = 8'h00;
                        tvalid_n = 1'b0;
                        tlast_n  = 1'b0;
                        done_n   = 1'b1;
                        if (tx_pause_req) begin
                            dest_n    = tx_pause_dest_addr;
                            val_n     = tx_pause_val;
                            pend_n    = 1'b0;
                            restart_n = 1'b1;
                        end else if (pend_flag) begin
                            dest_n    = pend_dest;
                            val_n     = pend_val;
                            pend_n    = 1'b0;
                            restart_n = 1'b1;
                        end else begin
                            busy_n = 1'b0;
                        end
                    end else begin
                        cnt_n   = nidx;
                        tlast_n = (nidx == LAST_IDX);
                        tdata_n = hdr_byte(nidx, dest_q, val_q);
                        if (cnt == 6'd17)
                            state_n = S_PAD;
`ifdef PAUSE_FCS_EN
                        if (cnt <= 6'd59)
                            crc_n = crc_upd;
                        if (cnt == 6'd59)
                            state_n = S_FCS;
                        // Byte 60 needs the CRC including byte 59, which is only in crc_upd yet.
                        if (nidx == 6'd60)
                            tdata_n = ~crc_upd[7:0];
                        else if (nidx > 6'd60) begin
                            case (nidx[1:0])
                                2'd1:    tdata_n = ~crc_q[15:8];
                                2'd2:    tdata_n = ~crc_q[23:16];
                                default: tdata_n = ~crc_q[31:24];
                            endcase
                        end
`endif
                    end
                end
            end
        endcase

        if (start) begin
            state_n  = S_HDR;
            cnt_n    = 6'd0;
            tvalid_n = 1'b1;
            tlast_n  = 1'b0;
            busy_n   = 1'b1;
            tdata_n  = restart ? dest_q[47:40] : tx_pause_dest_addr[47:40];
`ifdef PAUSE_FCS_EN
            crc_n    = 32'hFFFFFFFF;
`endif
        end
    end

    always_ff @(posedge tx_clk or negedge rstn) begin
        if (!rstn) begin
            state         <= S_IDLE;
            cnt           <= 6'd0;
            dest_q        <= '0;
            val_q         <= '0;
            pend_dest     <= '0;
            pend_val      <= '0;
            pend_flag     <= 1'b0;
            restart       <= 1'b0;
            pf_tdata      <= 8'h00;
            pf_tvalid     <= 1'b0;
            pf_tlast      <= 1'b0;
            tx_pause_busy <= 1'b0;
            tx_pause_done <= 1'b0;
`ifdef PAUSE_FCS_EN
            crc_q         <= '0;
`endif
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            dest_q        <= dest_n;
            val_q         <= val_n;
            pend_dest     <= pdest_n;
            pend_val      <= pval_n;
            pend_flag     <= pend_n;
            restart       <= restart_n;
            pf_tdata      <= tdata_n;
            pf_tvalid     <= tvalid_n;
            pf_tlast      <= tlast_n;
            tx_pause_busy <= busy_n;
            tx_pause_done <= done_n;
`ifdef PAUSE_FCS_EN
            crc_q         <= crc_n;
`endif
        end
    end

endmodule
